// File: rtl/alu_share_arb.sv
// alu_share_arb
// Two-requester round-robin arbiter and sequencer for one shared
// combinational 16-bit ALU. A request is accepted in IDLE. The ALU is
// driven from registered operands during EXEC, and its result and flags
// are captured at the end of EXEC. They are then held on a valid/ready
// response channel in RESP until the consumer takes them.
//
// Ports:
//   clk_i, rst_i                  clock, async active-low reset
//   reqN_valid/ready              request handshake, N = 0,1
//   reqN_ctrl[3:0]                {invertA, invertB, operation[1:0]}
//   reqN_src1/src2[15:0]          operands
//   alu_src1/src2, alu_invertA/B,
//   alu_operation                 registered drive to the shared ALU
//   alu_result, alu_zero,
//   alu_overflow                  combinational ALU outputs
//   rsp_valid/ready               response handshake
//   rsp_id, rsp_result,
//   rsp_zero, rsp_overflow        captured response
module alu_share_arb (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic [15:0] req0_src1,
  input  logic [15:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic [15:0] req1_src1,
  input  logic [15:0] req1_src2,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic        alu_invertA,
  output logic        alu_invertB,
  output logic [1:0]  alu_operation,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [15:0] src1;
    logic [15:0] src2;
  } op_t;

  typedef struct packed {
    logic        ovf;
    logic        zero;
    logic [15:0] result;
  } rsp_t;

  state_t state, state_nxt;
  op_t    op_q, req0_op, req1_op;
  rsp_t   rsp_q;
  logic   last, id;
  logic   grant, accept;

  assign req0_op = '{ctrl: req0_ctrl, src1: req0_src1, src2: req0_src2};
  assign req1_op = '{ctrl: req1_ctrl, src1: req1_src1, src2: req1_src2};

  // Only a tie consults the round-robin pointer; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last;
    else if (req1_valid)          grant = 1'b1;
  end

  // Ready is gated by rst_i as well, so it reads 0 during reset even though
  // the state register already sits in IDLE.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_i && (req0_valid || req1_valid)) begin
          req0_ready = ~grant;
          req1_ready = grant;
          accept     = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      id    <= 1'b0;
      op_q  <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= grant ? req1_op : req0_op;
        id   <= grant;
      end
      // The ALU has had the whole EXEC cycle to settle on op_q.
      if (state == EXEC)
        rsp_q <= '{ovf: alu_overflow, zero: alu_zero, result: alu_result};
      if (state == RESP && rsp_ready)
        last <= id;
    end
  end

  assign alu_src1      = op_q.src1;
  assign alu_src2      = op_q.src2;
  assign alu_invertA   = op_q.ctrl[3];
  assign alu_invertB   = op_q.ctrl[2];
  assign alu_operation = op_q.ctrl[1:0];

  assign rsp_valid    = (state == RESP);
  assign rsp_id       = id;
  assign rsp_result   = rsp_q.result;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.ovf;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic [15:0] req0_src1 = 0, req0_src2 = 0, req1_src1 = 0, req1_src2 = 0;
  logic [15:0] alu_src1, alu_src2, alu_result, rsp_result;
  logic        alu_invertA, alu_invertB, alu_zero, alu_overflow;
  logic [1:0]  alu_operation;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_overflow;

  int errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_invertA(alu_invertA),
    .alu_invertB(alu_invertB), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow)
  );

  // Behavioural ALU: ainvert/bnegate front end, AND/OR/ADD/SLT.
  // Returns {overflow, zero, result}.
  function automatic logic [17:0] alu_fn(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b, r;
    logic [16:0] sum;
    logic sov;
    a = c[3] ? ~x : x;
    b = c[2] ? ~y : y;
    sum = {1'b0, a} + {1'b0, b} + {16'b0, c[2]};
    sov = (a[15] == b[15]) && (sum[15] != a[15]);
    case (c[1:0])
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: r = sum[15:0];
      default: r = {15'b0, sum[15] ^ sov};
    endcase
    return {(c[1:0] == 2'b10) ? sov : 1'b0, r == 16'h0, r};
  endfunction

  assign {alu_overflow, alu_zero, alu_result} = alu_fn({alu_invertA, alu_invertB, alu_operation}, alu_src1, alu_src2);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Scoreboard model: tracks where the single in-flight operation is
  // (0 = none, 1 = issued last cycle, 2 = response owed), the tie-break
  // owner, the operands currently presented to the ALU and the held response.
  int          m_phase = 0;
  logic        m_last = 1'b1, m_id = 1'b0;
  logic [35:0] m_op = '0;
  logic [17:0] m_exp = '0, m_cap = '0;

  always @(negedge clk) begin
    logic g, e0, e1;
    if (!rst_n) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu", {alu_invertA, alu_invertB, alu_operation, alu_src1, alu_src2}, 0);
      chk("rst_rsp", {rsp_overflow, rsp_zero, rsp_result}, 0);
      m_phase = 0; m_last = 1'b1; m_id = 1'b0; m_op = '0; m_cap = '0;
    end else begin
      g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      e0 = (m_phase == 0) && req0_valid && !g;
      e1 = (m_phase == 0) && req1_valid && g;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("alu_drive", {alu_invertA, alu_invertB, alu_operation, alu_src1, alu_src2}, m_op);
      chk("rsp_valid", rsp_valid, m_phase == 2);
      chk("rsp_fields", {rsp_overflow, rsp_zero, rsp_result}, m_cap);
      if (m_phase == 2) chk("rsp_id", rsp_id, m_id);
      case (m_phase)
        0: if (e0 || e1) begin
             m_id  = g;
             m_op  = g ? {req1_ctrl, req1_src1, req1_src2} : {req0_ctrl, req0_src1, req0_src2};
             m_exp = alu_fn(m_op[35:32], m_op[31:16], m_op[15:0]);
             m_phase = 1;
           end
        1: begin m_cap = m_exp; m_phase = 2; end
        default: if (rsp_ready) begin m_last = m_id; m_phase = 0; end
      endcase
    end
  end

  task automatic drive_req(input bit r, input bit v, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    if (r) begin req1_valid = v; req1_ctrl = c; req1_src1 = a; req1_src2 = b; end
    else   begin req0_valid = v; req0_ctrl = c; req0_src1 = a; req0_src2 = b; end
  endtask

  // Issue one op on requester r, wait for its response with rsp_ready=1,
  // and pin latency and response contents against literal expectations.
  task automatic run_op(input string n, input bit r, input logic [3:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input bit ez, input bit eo);
    int acc, got;
    bit ok;
    drive_req(r, 1'b1, c, a, b);
    ok = 0; acc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) begin ok = 1; acc = cyc; end
      @(posedge clk); #1;
    end
    drive_req(r, 1'b0, c, a, b);
    if (!ok) begin chk({n, "_accept_timeout"}, 0, 1); return; end
    ok = 0; got = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; got = cyc; end
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin chk({n, "_rsp_timeout"}, 0, 1); return; end
    chk({n, "_latency"}, got - acc, 2);
    chk({n, "_id"}, rsp_id, r);
    chk({n, "_result"}, rsp_result, er);
    chk({n, "_zero"}, rsp_zero, ez);
    chk({n, "_ovf"}, rsp_overflow, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int ids[6];
    int cyc_acc[6];
    int n;
    int exp_order[6];
    bit saw;
    exp_order = '{0, 1, 0, 1, 0, 1};

    // Reset with random stimulus on every input.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      {req0_valid, req1_valid, rsp_ready} = 3'($urandom);
      req0_ctrl = 4'($urandom); req1_ctrl = 4'($urandom);
      req0_src1 = 16'($urandom); req0_src2 = 16'($urandom);
      req1_src1 = 16'($urandom); req1_src2 = 16'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1; req1_valid = 1'b0;
    run_op("first_op", 1'b0, 4'b0010, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    run_op("add", 1'b0, 4'b0010, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
    run_op("ovf", 1'b0, 4'b0010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("sub0", 1'b1, 4'b0110, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);
    run_op("slt", 1'b1, 4'b0111, 16'hFFFE, 16'h0003, 16'h0001, 1'b0, 1'b0);
    run_op("and", 1'b0, 4'b0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);

    // Contention: both valid continuously; last op came from requester 0,
    // so preface one requester-1 op to make requester 0 win the first tie.
    run_op("pre_tie", 1'b1, 4'b0001, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    drive_req(1'b0, 1'b1, 4'b0010, 16'h1000, 16'h0234);
    drive_req(1'b1, 1'b1, 4'b0000, 16'hF0F0, 16'h0FF0);
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ids[n] = req1_ready ? 1 : 0; cyc_acc[n] = cyc; n++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_count", n, 6);
    for (int i = 0; i < n; i++) begin
      chk("tie_order", ids[i], exp_order[i]);
      if (i > 0) chk("tie_spacing", cyc_acc[i] - cyc_acc[i-1], 3);
    end
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure: OR op from requester 1 held in RESP for 10 cycles.
    rsp_ready = 1'b0;
    drive_req(1'b1, 1'b1, 4'b0001, 16'h00F0, 16'h0F00);
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      saw = rsp_valid;
      @(posedge clk); #1;
      if (!rsp_valid) drive_req(1'b1, !(req1_ready === 1'b0 && i > 0) || 1'b1, 4'b0001, 16'h00F0, 16'h0F00);
    end
    chk("bp_reached_resp", saw, 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", {rsp_id, rsp_overflow, rsp_zero, rsp_result}, {1'b1, 1'b0, 1'b0, 16'h0FF0});
      chk("bp_ready", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
    end

    // Reset mid-RESP: outputs must drop before the next clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_ready", {req0_ready, req1_ready}, 0);
    chk("rst_mid_alu", {alu_invertA, alu_invertB, alu_operation, alu_src1, alu_src2}, 0);
    chk("rst_mid_rsp", rsp_result, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
